// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory, redirect and decode-side signals of the fetch front end
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                   INSTR_REQ;
  logic [XLEN-1:0]        INSTR_ADR;
  logic [31:0]            INSTR_READ;
  logic                   INSTR_VALID;
  logic                   REDIRECT;
  logic [XLEN-1:0]        REDIRECT_ADR;
  logic                   OUT_VALID;
  logic                   OUT_READY;
  logic [31:0]            OUT_INSTR;
  logic [XLEN-1:0]        OUT_PC;
  logic [$clog2(DEPTH):0] COUNT;
  modport master (
    output INSTR_REQ, INSTR_ADR, OUT_VALID, OUT_INSTR, OUT_PC, COUNT,
    input  INSTR_READ, INSTR_VALID, REDIRECT, REDIRECT_ADR, OUT_READY
  );
  modport slave (
    input  INSTR_REQ, INSTR_ADR, OUT_VALID, OUT_INSTR, OUT_PC, COUNT,
    output INSTR_READ, INSTR_VALID, REDIRECT, REDIRECT_ADR, OUT_READY
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: pipelined instruction fetch with in-order response FIFO and redirect discard
module fetch_queue #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic          CLK,
  input  logic          RES,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  logic            r_run;
  logic [XLEN-1:0] r_fetch_pc, r_resp_pc;
  logic [OW-1:0]   r_live, r_discard;
  logic [AW:0]     r_count;
  logic [AW-1:0]   r_wp, r_rp;
  logic [XLEN-1:0] r_pc_mem [DEPTH];
  logic [31:0]     r_ins_mem [DEPTH];
  logic            w_issue, w_drop, w_push, w_pop;
  logic [XLEN-1:0] w_target;
  logic [OW-1:0]   w_redir_discard;
  assign bus.INSTR_REQ = w_issue;
  assign bus.INSTR_ADR = r_fetch_pc;
  assign bus.OUT_VALID = r_count != '0;
  assign bus.OUT_INSTR = r_ins_mem[r_rp];
  assign bus.OUT_PC    = r_pc_mem[r_rp];
  assign bus.COUNT     = r_count;
  // credit-based issue (outstanding limit and FIFO room) and response classification
  always_comb begin
    w_target        = {bus.REDIRECT_ADR[XLEN-1:2], 2'b00};
    w_issue         = r_run & ~bus.REDIRECT
                    & (({1'b0, r_live} + {1'b0, r_discard}) < (OW+1)'(MAX_OUTSTANDING))
                    & ((32'(r_count) + 32'(r_live)) < 32'(DEPTH));
    w_drop          = bus.INSTR_VALID & (r_discard != '0);
    w_push          = bus.INSTR_VALID & (r_discard == '0) & (r_live != '0);
    w_pop           = bus.OUT_VALID & bus.OUT_READY;
    w_redir_discard = r_discard + r_live
                    - OW'(bus.INSTR_VALID & ((r_live != '0) | (r_discard != '0)));
  end
  // run flag: first edge after reset release enables fetching
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) r_run <= 1'b0;
    else r_run <= 1'b1;
  end
  // fetch and response PCs; a redirect restarts both at the word-aligned target
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
    end else if (bus.REDIRECT) begin
      r_fetch_pc <= w_target;
      r_resp_pc  <= w_target;
    end else begin
      if (w_issue) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      if (w_push) r_resp_pc <= r_resp_pc + XLEN'(4);
    end
  end
  // in-flight accounting: on redirect every live request becomes a discard
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_live    <= '0;
      r_discard <= '0;
    end else if (bus.REDIRECT) begin
      r_live    <= '0;
      r_discard <= w_redir_discard;
    end else begin
      r_live    <= r_live + OW'(w_issue) - OW'(w_push);
      r_discard <= r_discard - OW'(w_drop);
    end
  end
  // instruction FIFO; redirect empties it and suppresses same-cycle push and pop
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]  <= '0;
        r_ins_mem[i] <= '0;
      end
    end else if (bus.REDIRECT) begin
      r_wp    <= r_rp;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wp]  <= r_resp_pc;
        r_ins_mem[r_wp] <= bus.INSTR_READ;
        r_wp            <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven scenarios plus redirect/reset sequences against a memory model and scoreboard
module tb_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  typedef struct {logic [31:0] adr; int due; int ep;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} out_t;
  typedef struct {int lat; bit rdy; int ncyc; int reqs; int pops; int cnt;} vec_t;
  logic clk = 1'b0;
  logic res;
  req_t pend[$];
  out_t sb[$];
  int n_vec = 0, n_err = 0, cyc = 0, lat = 1, epoch = 0, nreq = 0, npop = 0, last_cnt = 0;
  logic [31:0] exp_fetch, first_req, first_out, last_req;
  bit got_req, got_out;
  always #5 clk = ~clk;
  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC('0)) dut (
    .CLK(clk),
    .RES(res),
    .bus(bus)
  );
  function automatic logic [31:0] instr_of(logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction
  task automatic clear_capture();
    got_req = 0;
    got_out = 0;
    first_req = 'x;
    first_out = 'x;
  endtask
  task automatic tick();
    bit v = 0;
    int nlive = 0;
    req_t e;
    if (res && pend.size() > 0 && pend[0].due <= cyc) v = 1;
    bus.INSTR_VALID = res ? v : 1'b1;
    bus.INSTR_READ = v ? instr_of(pend[0].adr) : $urandom;
    #1;
    if (!res) begin
      chk("rst_req", bus.INSTR_REQ, 0);
      chk("rst_adr", bus.INSTR_ADR, 0);
      chk("rst_out_valid", bus.OUT_VALID, 0);
      chk("rst_out_instr", bus.OUT_INSTR, 0);
      chk("rst_out_pc", bus.OUT_PC, 0);
      chk("rst_count", bus.COUNT, 0);
    end else begin
      chk("count", bus.COUNT, sb.size());
      chk("out_valid", bus.OUT_VALID, sb.size() != 0);
      if (bus.OUT_VALID && sb.size() > 0) begin
        chk("out_pc", bus.OUT_PC, sb[0].pc);
        chk("out_instr", bus.OUT_INSTR, sb[0].ins);
      end
      last_cnt = int'(bus.COUNT);
      if (bus.REDIRECT) chk("redir_noreq", bus.INSTR_REQ, 0);
      if (bus.INSTR_REQ) begin
        foreach (pend[i]) if (pend[i].ep == epoch) nlive++;
        chk("req_adr", bus.INSTR_ADR, exp_fetch);
        chk("req_outstanding", pend.size() < MAXO, 1);
        chk("req_credit", sb.size() + nlive < DEPTH, 1);
        if (!got_req) begin
          got_req = 1;
          first_req = bus.INSTR_ADR;
        end
        last_req = bus.INSTR_ADR;
        nreq++;
        pend.push_back('{bus.INSTR_ADR, cyc + lat, epoch});
        exp_fetch += 32'd4;
      end
      if (v) begin
        e = pend.pop_front();
        if (e.ep == epoch && !bus.REDIRECT) sb.push_back('{e.adr, instr_of(e.adr)});
      end
      if (bus.OUT_VALID && bus.OUT_READY && !bus.REDIRECT && sb.size() > 0) begin
        if (!got_out) begin
          got_out = 1;
          first_out = bus.OUT_PC;
        end
        void'(sb.pop_front());
        npop++;
      end
      if (bus.REDIRECT) begin
        sb.delete();
        epoch++;
        exp_fetch = {bus.REDIRECT_ADR[31:2], 2'b00};
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  task automatic do_reset(int l);
    res = 0;
    pend.delete();
    sb.delete();
    epoch++;
    exp_fetch = '0;
    lat = l;
    bus.REDIRECT = 0;
    bus.OUT_READY = 0;
    repeat (2) tick();
    res = 1;
    clear_capture();
    nreq = 0;
    npop = 0;
  endtask
  initial begin
    vec_t tbl [4];
    res = 0;
    bus.INSTR_VALID = 0;
    bus.INSTR_READ = '0;
    bus.REDIRECT = 0;
    bus.REDIRECT_ADR = '0;
    bus.OUT_READY = 0;
    tbl[0] = '{1, 1'b1, 10, 9, 7, 1};
    tbl[1] = '{1, 1'b0, 8, 4, 0, 4};
    tbl[2] = '{3, 1'b1, 12, 6, 4, 0};
    tbl[3] = '{2, 1'b1, 10, 6, 4, 0};
    @(negedge clk);
    foreach (tbl[i]) begin
      do_reset(tbl[i].lat);
      bus.OUT_READY = tbl[i].rdy;
      repeat (tbl[i].ncyc) tick();
      chk("tbl_reqs", nreq, tbl[i].reqs);
      chk("tbl_pops", npop, tbl[i].pops);
      chk("tbl_count", last_cnt, tbl[i].cnt);
      chk("tbl_first_req", first_req, 0);
    end
    do_reset(1);
    repeat (8) tick();
    bus.OUT_READY = 1;
    tick();
    bus.OUT_READY = 0;
    nreq = 0;
    repeat (4) tick();
    chk("stall_one_req", nreq, 1);
    chk("stall_req_adr", last_req, 32'h10);
    chk("stall_count", last_cnt, 4);
    do_reset(3);
    bus.OUT_READY = 1;
    repeat (3) tick();
    clear_capture();
    bus.REDIRECT = 1;
    bus.REDIRECT_ADR = 32'h103;
    tick();
    bus.REDIRECT = 0;
    repeat (12) tick();
    chk("redir_first_req", first_req, 32'h100);
    chk("redir_first_out", first_out, 32'h100);
    do_reset(1);
    bus.OUT_READY = 1;
    repeat (5) tick();
    clear_capture();
    bus.REDIRECT = 1;
    bus.REDIRECT_ADR = 32'h40;
    tick();
    bus.REDIRECT_ADR = 32'h200;
    tick();
    bus.REDIRECT = 0;
    repeat (8) tick();
    chk("b2b_first_req", first_req, 32'h200);
    chk("b2b_first_out", first_out, 32'h200);
    do_reset(3);
    repeat (7) tick();
    chk("mid_count", last_cnt, 2);
    do_reset(1);
    bus.OUT_READY = 1;
    repeat (6) tick();
    chk("rst_restart_req", first_req, 0);
    chk("rst_restart_out", first_out, 0);
    chk("rst_restart_nreq", nreq, 5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end that replaces the single-entry PC plus instruction buffer pair.
- Keeps up to MAX_OUTSTANDING pipelined requests in flight on the instruction-memory req/valid interface.
- Buffers returned instructions, each tagged with its PC, in a DEPTH-entry FIFO that the decode stage drains.
- Handles branch/jump redirects: clears the queue and discards responses from requests issued before the redirect.

Parameters:
XLEN, 32, address/PC width
DEPTH, 4, instruction FIFO entries; power of two, >=2
MAX_OUTSTANDING, 2, maximum in-flight memory requests, including requests marked for discard; >=1
RESET_PC, 0, first fetch address after reset

Ports:
CLK  in  1  clock, rising edge
RES  in  1  reset, asynchronous, active-low
INSTR_REQ  out  1  fetch request; the request issues on a CLK edge where INSTR_REQ=1
INSTR_ADR  out  XLEN  fetch address, valid while INSTR_REQ=1
INSTR_READ  in  32  returned instruction word
INSTR_VALID  in  1  response strobe; responses return in order, latency >=1 cycle
REDIRECT  in  1  one-cycle pulse to restart fetch at REDIRECT_ADR
REDIRECT_ADR  in  XLEN  redirect target; bits [1:0] ignored, forced to 0
OUT_VALID  out  1  FIFO head valid
OUT_READY  in  1  consumer accepts the head on an edge where OUT_VALID & OUT_READY
OUT_INSTR  out  32  head instruction
OUT_PC  out  XLEN  address of the head instruction
COUNT  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values while RES=0:
  - INSTR_REQ=0, INSTR_ADR=RESET_PC, OUT_VALID=0, OUT_INSTR=0, OUT_PC=0, COUNT=0.
  - Internal counters are 0 and the run flag is clear.
  - A reset asserted mid-operation aborts everything; responses arriving during reset are ignored.
- Run flag:
  - Set on the first CLK edge after RES rises.
  - INSTR_REQ is forced 0 while the run flag is clear.
- State:
  - fetch_pc: next address to request.
  - resp_pc: PC of the next live response.
  - live: in-flight requests whose data will be kept.
  - discard: in-flight requests whose data will be dropped.
  - FIFO of {pc, instr}.
- Issue rule: INSTR_REQ = run & ~REDIRECT & (live+discard < MAX_OUTSTANDING) & (COUNT+live < DEPTH).
  - This credit scheme guarantees the FIFO never overflows.
  - INSTR_ADR=fetch_pc. When a request issues, fetch_pc += 4 and live += 1.
  - fetch_pc wraps modulo 2^XLEN.
- Response handling on INSTR_VALID=1:
  - If discard>0: discard -= 1 and the data is dropped.
  - Else if live>0: push {resp_pc, INSTR_READ}, then resp_pc += 4 and live -= 1.
  - Else (spurious response): ignore it.
  - Issue and response may occur in the same cycle; the counters update net.
- Dequeue: on OUT_VALID & OUT_READY, pop the head.
  - Push and pop in the same cycle leave COUNT unchanged.
  - A push into an empty FIFO is visible at OUT_VALID the next cycle. Zero-latency bypass is not allowed.
- Redirect (REDIRECT=1 at an edge) has priority over everything else in that cycle:
  - fetch_pc and resp_pc <= {REDIRECT_ADR[XLEN-1:2],2'b00}.
  - FIFO is cleared; COUNT=0 and OUT_VALID=0 next cycle. A same-cycle pop or push has no effect.
  - discard <= discard + live - (1 if INSTR_VALID that cycle); live <= 0.
  - No request issues in the redirect cycle. Fetch resumes the next cycle at the target, subject to the issue rule.
  - Back-to-back redirects: the last one wins, and the discard accounting stays exact.
- Full FIFO: no issue once COUNT+live=DEPTH; issue resumes the cycle after a pop frees a credit.
- Empty FIFO: OUT_VALID=0; OUT_INSTR/OUT_PC hold their last values (don't-care to the consumer).
- Throughput: with 1-cycle memory latency, MAX_OUTSTANDING>=2 and OUT_READY=1, steady state is one instruction per cycle.

Test Plan:
- Reset, then release with memory latency 1 and OUT_READY=1 -> requests to 0x0, 0x4, 0x8… on consecutive cycles; OUT_PC matches each address; OUT_VALID is first high 2 cycles after the first request.
- OUT_READY=0, DEPTH=4 -> exactly 4 requests issue (0x0–0xC), then INSTR_REQ=0 with COUNT=4. Pulse OUT_READY for one cycle -> one pop, and one request to 0x10 the next cycle.
- Latency 3, MAX_OUTSTANDING=2 -> at most 2 requests are unanswered at any time; in-order data is tagged 0x0, 0x4, 0x8.
- With 2 requests in flight, REDIRECT to 0x103 -> COUNT=0 next cycle; the next two INSTR_VALID are dropped; the next request is to 0x100, and the first queued OUT_PC=0x100.
- REDIRECT coincident with INSTR_VALID and a pop, then a second REDIRECT next cycle to 0x200 -> no stale instruction ever reaches OUT_VALID; first output PC=0x200.
- RES pulled low while 2 requests are in flight and the FIFO is partly full -> all outputs go to reset values immediately; after release, fetch restarts at RESET_PC with no leftover discards.
